// File: rtl/lock_pkg.sv
// Shared definitions for the lock controller: state encodings, field widths
// and the seconds-to-timer-load conversion used when sizing dwell times.
package lock_pkg;

   localparam int STATE_W = 3;
   localparam int CNT_W   = 4;
   localparam int TMR_W   = 32;

   localparam logic [STATE_W-1:0] LOCKED = 3'd0;
   localparam logic [STATE_W-1:0] CHECK  = 3'd1;
   localparam logic [STATE_W-1:0] OPEN   = 3'd2;
   localparam logic [STATE_W-1:0] FAIL   = 3'd3;
   localparam logic [STATE_W-1:0] ALARM  = 3'd4;

   // The timer exits on the cycle it reads zero, so a dwell of N cycles loads N-1.
   function automatic logic [TMR_W-1:0] dwell_load(input int freq, input int sec);
      return TMR_W'(freq * sec - 1);
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Shared 32-bit dwell down-counter: loads on request, counts to zero and
// holds there, flagging done while it reads zero.
module lock_timer
   import lock_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             done
);

   logic [TMR_W-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - TMR_W'(1);
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/lock_fsm.sv
// Lock-control state machine behind the password comparator: opens on a
// match, flags wrong codes, and enters a timed alarm after MAX_FAIL misses.
module lock_fsm
   import lock_pkg::*;
#(
   parameter int CLK_FREQ  = 12_000_000,
   parameter int OPEN_SEC  = 3,
   parameter int FAIL_SEC  = 1,
   parameter int ALARM_SEC = 10,
   parameter int MAX_FAIL  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enter_trig,
   input  logic               com_result,
   output logic               unlock,
   output logic               err,
   output logic               alarm,
   output logic [CNT_W-1:0]   fail_cnt,
   output logic [STATE_W-1:0] state_o
);

   localparam logic [TMR_W-1:0] OPEN_LOAD  = dwell_load(CLK_FREQ, OPEN_SEC);
   localparam logic [TMR_W-1:0] FAIL_LOAD  = dwell_load(CLK_FREQ, FAIL_SEC);
   localparam logic [TMR_W-1:0] ALARM_LOAD = dwell_load(CLK_FREQ, ALARM_SEC);
   localparam logic [CNT_W:0]   MAX_FAIL_W = (CNT_W + 1)'(MAX_FAIL);

   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   fail_q, fail_d;
   logic               unlock_q, err_q, alarm_q;
   logic               tmr_load, tmr_done;
   logic [TMR_W-1:0]   tmr_val;

   lock_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // CHECK always leaves for a timed state, so it is the only place the timer loads.
   assign tmr_load = (state_q == CHECK);

   always_comb begin
      state_d = state_q;
      fail_d  = fail_q;
      case (state_q)
         LOCKED: begin
            if (enter_trig) state_d = CHECK;
         end
         CHECK: begin
            if (com_result) begin
               state_d = OPEN;
               fail_d  = '0;
            end else if (({1'b0, fail_q} + 1'b1) >= MAX_FAIL_W) begin
               state_d = ALARM;
               fail_d  = MAX_FAIL_W[CNT_W-1:0];
            end else begin
               state_d = FAIL;
               fail_d  = fail_q + 1'b1;
            end
         end
         OPEN, FAIL: begin
            if (tmr_done) state_d = LOCKED;
         end
         ALARM: begin
            if (tmr_done) begin
               state_d = LOCKED;
               fail_d  = '0;
            end
         end
         default: state_d = LOCKED;
      endcase
   end

   always_comb begin
      case (state_d)
         FAIL:    tmr_val = FAIL_LOAD;
         ALARM:   tmr_val = ALARM_LOAD;
         default: tmr_val = OPEN_LOAD;
      endcase
   end

   // Indicators are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= LOCKED;
         fail_q   <= '0;
         unlock_q <= 1'b0;
         err_q    <= 1'b0;
         alarm_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         fail_q   <= fail_d;
         unlock_q <= (state_d == OPEN);
         err_q    <= (state_d == FAIL);
         alarm_q  <= (state_d == ALARM);
      end
   end

   assign unlock   = unlock_q;
   assign err      = err_q;
   assign alarm    = alarm_q;
   assign fail_cnt = fail_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_lock_fsm.sv
// Self-checking bench for lock_fsm: each step queues the stimulus for one cycle
// together with the outputs expected in the following cycle.
module tb_lock_fsm;
   import lock_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       enter_trig;
   logic       com_result;
   logic       unlock, err, alarm;
   logic [3:0] fail_cnt;
   logic [2:0] state_o;
   logic [9:0] obs;

   typedef struct packed {
      logic       en;
      logic       com;
      logic [9:0] ex;
   } step_t;

   step_t stepq[$];
   int    tests_run    = 0;
   int    tests_failed = 0;

   always #5 clk = ~clk;

   lock_fsm #(
      .CLK_FREQ  (4),
      .OPEN_SEC  (1),
      .FAIL_SEC  (1),
      .ALARM_SEC (2),
      .MAX_FAIL  (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enter_trig (enter_trig),
      .com_result (com_result),
      .unlock     (unlock),
      .err        (err),
      .alarm      (alarm),
      .fail_cnt   (fail_cnt),
      .state_o    (state_o)
   );

   assign obs = {state_o, unlock, err, alarm, fail_cnt};

   // Queue n cycles of stimulus (en, com) with the outputs expected one cycle later.
   task automatic push(input logic en, input logic com, input logic [2:0] st,
                       input logic u, input logic e, input logic a,
                       input logic [3:0] fc, input int n);
      for (int i = 0; i < n; i++) stepq.push_back('{en, com, {st, u, e, a, fc}});
   endtask

   task automatic test_reset();
      step_t it;
      rst = 1'b1; enter_trig = 1'b0; com_result = 1'b0;
      #1;
      tests_run++;
      if (obs !== 10'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: got %b required %b", obs, 10'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      push(0, 0, LOCKED, 0, 0, 0, 0, 2);
      for (int n = 0; stepq.size() > 0; n++) begin
         it = stepq.pop_front();
         enter_trig = it.en; com_result = it.com;
         @(negedge clk);
         tests_run++;
         if (obs !== it.ex) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle step %0d: got %b required %b", n, obs, it.ex);
         end
      end
   endtask

   task automatic test_open();
      step_t it;
      push(1, 1, CHECK,  0, 0, 0, 0, 1);
      push(0, 1, OPEN,   1, 0, 0, 0, 4);
      push(0, 1, LOCKED, 0, 0, 0, 0, 2);
      for (int n = 0; stepq.size() > 0; n++) begin
         it = stepq.pop_front();
         enter_trig = it.en; com_result = it.com;
         @(negedge clk);
         tests_run++;
         if (obs !== it.ex) begin
            tests_failed++;
            $display("[TB] FAIL open step %0d: got %b required %b", n, obs, it.ex);
         end
      end
   endtask

   task automatic test_wrong_then_right();
      step_t it;
      push(1, 0, CHECK,  0, 0, 0, 0, 1);
      push(0, 0, FAIL,   0, 1, 0, 1, 4);
      push(0, 0, LOCKED, 0, 0, 0, 1, 1);
      push(1, 0, CHECK,  0, 0, 0, 1, 1);
      push(0, 0, FAIL,   0, 1, 0, 2, 4);
      push(0, 0, LOCKED, 0, 0, 0, 2, 1);
      push(1, 1, CHECK,  0, 0, 0, 2, 1);
      push(0, 1, OPEN,   1, 0, 0, 0, 4);
      push(0, 1, LOCKED, 0, 0, 0, 0, 1);
      for (int n = 0; stepq.size() > 0; n++) begin
         it = stepq.pop_front();
         enter_trig = it.en; com_result = it.com;
         @(negedge clk);
         tests_run++;
         if (obs !== it.ex) begin
            tests_failed++;
            $display("[TB] FAIL wrong_right step %0d: got %b required %b", n, obs, it.ex);
         end
      end
   endtask

   task automatic test_alarm();
      step_t it;
      push(1, 0, CHECK,  0, 0, 0, 0, 1);
      push(0, 0, FAIL,   0, 1, 0, 1, 4);
      push(0, 0, LOCKED, 0, 0, 0, 1, 1);
      push(1, 0, CHECK,  0, 0, 0, 1, 1);
      push(0, 0, FAIL,   0, 1, 0, 2, 4);
      push(0, 0, LOCKED, 0, 0, 0, 2, 1);
      push(1, 0, CHECK,  0, 0, 0, 2, 1);
      push(0, 0, ALARM,  0, 0, 1, 3, 3);
      push(1, 1, ALARM,  0, 0, 1, 3, 1);
      push(0, 1, ALARM,  0, 0, 1, 3, 3);
      push(1, 1, ALARM,  0, 0, 1, 3, 1);
      push(1, 1, LOCKED, 0, 0, 0, 0, 1);
      push(0, 1, LOCKED, 0, 0, 0, 0, 1);
      for (int n = 0; stepq.size() > 0; n++) begin
         it = stepq.pop_front();
         enter_trig = it.en; com_result = it.com;
         @(negedge clk);
         tests_run++;
         if (obs !== it.ex) begin
            tests_failed++;
            $display("[TB] FAIL alarm step %0d: got %b required %b", n, obs, it.ex);
         end
      end
   endtask

   task automatic test_ignore_enter();
      step_t it;
      push(1, 1, CHECK,  0, 0, 0, 0, 1);
      push(1, 1, OPEN,   1, 0, 0, 0, 1);
      push(1, 1, OPEN,   1, 0, 0, 0, 1);
      push(0, 1, OPEN,   1, 0, 0, 0, 1);
      push(1, 1, OPEN,   1, 0, 0, 0, 1);
      push(1, 1, LOCKED, 0, 0, 0, 0, 1);
      push(0, 1, LOCKED, 0, 0, 0, 0, 1);
      push(1, 0, CHECK,  0, 0, 0, 0, 1);
      push(1, 0, FAIL,   0, 1, 0, 1, 2);
      push(0, 0, FAIL,   0, 1, 0, 1, 1);
      push(1, 0, FAIL,   0, 1, 0, 1, 1);
      push(1, 1, LOCKED, 0, 0, 0, 1, 1);
      push(0, 1, LOCKED, 0, 0, 0, 1, 1);
      for (int n = 0; stepq.size() > 0; n++) begin
         it = stepq.pop_front();
         enter_trig = it.en; com_result = it.com;
         @(negedge clk);
         tests_run++;
         if (obs !== it.ex) begin
            tests_failed++;
            $display("[TB] FAIL ignore step %0d: got %b required %b", n, obs, it.ex);
         end
      end
   endtask

   task automatic test_back_to_back();
      step_t it;
      push(1, 0, CHECK,  0, 0, 0, 1, 1);
      push(0, 0, FAIL,   0, 1, 0, 2, 4);
      push(0, 0, LOCKED, 0, 0, 0, 2, 1);
      push(1, 1, CHECK,  0, 0, 0, 2, 1);
      push(0, 1, OPEN,   1, 0, 0, 0, 4);
      push(0, 1, LOCKED, 0, 0, 0, 0, 1);
      push(1, 0, CHECK,  0, 0, 0, 0, 1);
      push(0, 0, FAIL,   0, 1, 0, 1, 4);
      push(0, 0, LOCKED, 0, 0, 0, 1, 1);
      for (int n = 0; stepq.size() > 0; n++) begin
         it = stepq.pop_front();
         enter_trig = it.en; com_result = it.com;
         @(negedge clk);
         tests_run++;
         if (obs !== it.ex) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back step %0d: got %b required %b", n, obs, it.ex);
         end
      end
   endtask

   task automatic test_reset_mid();
      step_t it;
      for (int ph = 0; ph < 3; ph++) begin
         if (ph == 0) begin
            push(1, 1, CHECK,  0, 0, 0, 1, 1);
            push(0, 1, OPEN,   1, 0, 0, 0, 2);
         end else begin
            push(1, 1, CHECK,  0, 0, 0, 0, 1);
            push(0, 1, OPEN,   1, 0, 0, 0, 4);
            push(0, 1, LOCKED, 0, 0, 0, 0, 1);
         end
         if (ph == 1) begin
            push(1, 0, CHECK,  0, 0, 0, 0, 1);
            push(0, 0, FAIL,   0, 1, 0, 1, 4);
            push(0, 0, LOCKED, 0, 0, 0, 1, 1);
            push(1, 0, CHECK,  0, 0, 0, 1, 1);
            push(0, 0, FAIL,   0, 1, 0, 2, 4);
            push(0, 0, LOCKED, 0, 0, 0, 2, 1);
            push(1, 0, CHECK,  0, 0, 0, 2, 1);
            push(0, 0, ALARM,  0, 0, 1, 3, 3);
         end
         for (int n = 0; stepq.size() > 0; n++) begin
            it = stepq.pop_front();
            enter_trig = it.en; com_result = it.com;
            @(negedge clk);
            tests_run++;
            if (obs !== it.ex) begin
               tests_failed++;
               $display("[TB] FAIL reset_mid ph%0d step %0d: got %b required %b", ph, n, obs, it.ex);
            end
         end
         enter_trig = 1'b0;
         if (ph < 2) begin
            #2 rst = 1'b1;
            #1;
            tests_run++;
            if (obs !== 10'd0) begin
               tests_failed++;
               $display("[TB] FAIL reset_async ph%0d: got %b required %b", ph, obs, 10'd0);
            end
            @(negedge clk);
            rst = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_open();
      test_wrong_then_right();
      test_alarm();
      test_ignore_enter();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
